// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core, with retired-instruction counter.
// Optional: define MC_CTRL_TRAP_EN to trap on illegal opcodes (adds illegal_o).
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [3:0]       state_o,
`ifdef MC_CTRL_TRAP_EN
  output logic             illegal_o,
`endif
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign taken = (funct3 == 3'b000 &&  zero) ||
                 (funct3 == 3'b001 && !zero);

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    case (op)
      OP_SW:   imm_src = 3'b001;
      OP_BR:   imm_src = 3'b010;
      OP_LUI:  imm_src = 3'b011;
      OP_JAL:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BR:        state_d = BRANCH;
          OP_LUI:       state_d = LUI;
`ifdef MC_CTRL_TRAP_EN
          default:      state_d = TRAP;
`else
          default: begin
            // unknown opcode retires as a nop
            state_d = FETCH;
            retire  = 1'b1;
          end
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = ALUWB;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // reset overrides everything combinational, including mid-store mem_write
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      imm_src    = 3'b000;
    end
  end

  assign cnt_d     = cnt_q + CNT_W'(retire);
  assign state_o   = state_q;
  assign instret_o = cnt_q;
`ifdef MC_CTRL_TRAP_EN
  assign illegal_o = (state_q == TRAP) && !rst;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl with a per-cycle scoreboard.
// Covers each instruction class, stalls, branch outcomes, reset and counter wrap.
module tb_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] II  = 7'b0010011;
  localparam logic [6:0] JJ  = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BAD = 7'b0000000;

  // {adr_src, result_src, alu_src_a, alu_src_b, alu_op}
  localparam logic [8:0] S_F   = 9'b0_10_00_10_00;
  localparam logic [8:0] S_D   = 9'b0_00_01_01_00;
  localparam logic [8:0] S_MA  = 9'b0_00_10_01_00;
  localparam logic [8:0] S_MR  = 9'b1_00_00_00_00;
  localparam logic [8:0] S_MWB = 9'b0_01_00_00_00;
  localparam logic [8:0] S_MW  = 9'b1_00_00_00_00;
  localparam logic [8:0] S_ER  = 9'b0_00_10_00_10;
  localparam logic [8:0] S_EI  = 9'b0_00_10_01_10;
  localparam logic [8:0] S_L   = 9'b0_00_11_01_00;
  localparam logic [8:0] S_J   = 9'b0_00_01_10_00;
  localparam logic [8:0] S_WB  = 9'b0_00_00_00_00;
  localparam logic [8:0] S_BR  = 9'b0_00_10_00_01;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [3:0]  en;
    logic [8:0]  sel;
    logic [2:0]  imm;
    logic        ret;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, adr_src;
  logic        mem_write, reg_write;
  logic [1:0]  result_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic [2:0]  imm_src;
  logic [3:0]  state_o, state4;
  logic [31:0] instret_o;
  logic        pcw4, irw4, adr4, mw4, rw4;
  logic [1:0]  rs4, sa4, sb4, aop4;
  logic [2:0]  imm4;
  logic [3:0]  instret4;
`ifdef MC_CTRL_TRAP_EN
  logic        illegal_o, ill4;
`endif

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op),
    .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write),
    .result_src(result_src),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src),
    .state_o(state_o),
`ifdef MC_CTRL_TRAP_EN
    .illegal_o(illegal_o),
`endif
    .instret_o(instret_o)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op(op),
    .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pcw4), .ir_write(irw4),
    .adr_src(adr4), .mem_write(mw4),
    .reg_write(rw4), .result_src(rs4),
    .alu_src_a(sa4), .alu_src_b(sb4),
    .alu_op(aop4), .imm_src(imm4),
    .state_o(state4),
`ifdef MC_CTRL_TRAP_EN
    .illegal_o(ill4),
`endif
    .instret_o(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errs;
  int   checks;
  vec_t tbl[$];
  vec_t sb[$];
  logic [31:0] cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp,
                     input int row);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s row %0d: got %0h want %0h",
               nm, row, act, exp);
    end
  endtask

  task automatic r(input logic rs,
                   input logic [6:0] o,
                   input logic [2:0] f,
                   input logic zz, input logic m,
                   input logic [3:0] s,
                   input logic [3:0] e,
                   input logic [8:0] sl,
                   input logic [2:0] im,
                   input logic rt, input logic il);
    vec_t v;
    v.rst = rs; v.op = o; v.f3 = f;
    v.z = zz; v.mr = m; v.st = s;
    v.en = e; v.sel = sl; v.imm = im;
    v.ret = rt; v.ill = il; v.cnt = '0;
    tbl.push_back(v);
  endtask

  task automatic rr(input logic [6:0] o,
                    input logic m,
                    input logic [3:0] s);
    r(1, o, 0, 0, m, s, 4'b0000, S_WB, 0, 0, 0);
  endtask

  task automatic fe(input logic [6:0] o,
                    input logic [2:0] im,
                    input logic m);
    r(0, o, 0, 0, m, 0, m ? 4'b1100 : 4'b0000,
      S_F, im, 0, 0);
  endtask

  task automatic dec(input logic [6:0] o,
                     input logic [2:0] im);
    r(0, o, 0, 0, 1, 1, 4'b0000, S_D, im, 0, 0);
  endtask

  task automatic br(input logic [2:0] f,
                    input logic zz,
                    input logic tk);
    fe(BR, 3'b010, 1);
    dec(BR, 3'b010);
    r(0, BR, f, zz, 1, 10,
      tk ? 4'b1000 : 4'b0000,
      S_BR, 3'b010, 1, 0);
  endtask

  task automatic lui();
    fe(LU, 3'b011, 1);
    dec(LU, 3'b011);
    r(0, LU, 0, 0, 1, 11, 4'b0000, S_L, 3'b011, 0, 0);
    r(0, LU, 0, 0, 1, 7, 4'b0001, S_WB, 3'b011, 1, 0);
  endtask

  initial begin
    errs = 0; checks = 0; cnt = 0;
    rst = 1'b1; op = RR; funct3 = 0;
    zero = 0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    rr(RR, 1, 0);
    rr(RR, 1, 0);
    // add
    fe(RR, 0, 1);
    dec(RR, 0);
    r(0, RR, 0, 0, 1, 6, 4'b0000, S_ER, 0, 0, 0);
    r(0, RR, 0, 0, 1, 7, 4'b0001, S_WB, 0, 1, 0);
    // sw, memory stalls three cycles
    fe(SW, 1, 1);
    dec(SW, 1);
    r(0, SW, 0, 0, 1, 2, 4'b0000, S_MA, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      r(0, SW, 0, 0, 0, 5, 4'b0010, S_MW, 1, 0, 0);
    r(0, SW, 0, 0, 1, 5, 4'b0010, S_MW, 1, 1, 0);
    // lw with fetch stall and read stall
    fe(LW, 0, 0);
    fe(LW, 0, 1);
    dec(LW, 0);
    r(0, LW, 0, 0, 1, 2, 4'b0000, S_MA, 0, 0, 0);
    r(0, LW, 0, 0, 0, 3, 4'b0000, S_MR, 0, 0, 0);
    r(0, LW, 0, 0, 1, 3, 4'b0000, S_MR, 0, 0, 0);
    r(0, LW, 0, 0, 1, 4, 4'b0001, S_MWB, 0, 1, 0);
    // branches
    br(3'b000, 1, 1);
    br(3'b000, 0, 0);
    br(3'b001, 0, 1);
    br(3'b001, 1, 0);
    br(3'b100, 1, 0);
    // jal, lui
    fe(JJ, 3'b100, 1);
    dec(JJ, 3'b100);
    r(0, JJ, 0, 0, 1, 9, 4'b1000, S_J, 3'b100, 0, 0);
    r(0, JJ, 0, 0, 1, 7, 4'b0001, S_WB, 3'b100, 1, 0);
    lui();
    // addi, mem_ready low where it must be ignored
    fe(II, 0, 1);
    r(0, II, 0, 0, 0, 1, 4'b0000, S_D, 0, 0, 0);
    r(0, II, 0, 0, 0, 8, 4'b0000, S_EI, 0, 0, 0);
    r(0, II, 0, 0, 0, 7, 4'b0001, S_WB, 0, 1, 0);
    // illegal opcode
    fe(BAD, 0, 1);
`ifdef MC_CTRL_TRAP_EN
    dec(BAD, 0);
    for (int k = 0; k < 10; k++)
      r(0, BAD, 0, 0, 1, 12, 4'b0000, S_WB, 0, 0, 1);
    rr(BAD, 1, 12);
`else
    r(0, BAD, 0, 0, 1, 1, 4'b0000, S_D, 0, 1, 0);
`endif
    // reset in the middle of a stalled store
    fe(SW, 1, 1);
    dec(SW, 1);
    r(0, SW, 0, 0, 1, 2, 4'b0000, S_MA, 1, 0, 0);
    r(0, SW, 0, 0, 0, 5, 4'b0010, S_MW, 1, 0, 0);
    r(1, SW, 0, 0, 0, 5, 4'b0000, S_WB, 0, 0, 0);
    fe(RR, 0, 0);
    // 16 retirements wrap the 4-bit counter
    for (int k = 0; k < 16; k++) lui();
    fe(RR, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v, e;
      v = tbl[i];
      rst = v.rst; op = v.op;
      funct3 = v.f3; zero = v.z;
      mem_ready = v.mr;
      v.cnt = cnt;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      chk("state", 32'(state_o), 32'(e.st), i);
      chk("enables",
          32'({pc_write, ir_write,
               mem_write, reg_write}),
          32'(e.en), i);
      chk("selects",
          32'({adr_src, result_src,
               alu_src_a, alu_src_b, alu_op}),
          32'(e.sel), i);
      chk("imm_src", 32'(imm_src), 32'(e.imm), i);
      chk("instret", instret_o, e.cnt, i);
      chk("instret4", 32'(instret4),
          32'(e.cnt[3:0]), i);
`ifdef MC_CTRL_TRAP_EN
      chk("illegal", 32'(illegal_o), 32'(e.ill), i);
`endif
      @(posedge clk);
      #1;
      if (e.rst) cnt = 0;
      else if (e.ret) cnt = cnt + 1;
    end

    @(negedge clk);
    chk("wrap_final", 32'(instret4), 32'd0, -1);
    chk("count_final", instret_o, 32'd16, -1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
